// File: rtl/high_frequency_apb.sv
// A-clock side APB completer of the asynchronous APB bridge: registers one transfer,
// hands it to the B side with a request toggle and stalls until the acknowledge toggle returns.
module high_frequency_apb #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  parameter int STRB_WD = 4,
  parameter int PROT_WD = 3
) (
  input  logic               a_pclk,
  input  logic               a_prst,
  input  logic               a_psel,
  input  logic               a_penable,
  input  logic               a_pwrite,
  input  logic [ADDR_WD-1:0] a_paddr,
  input  logic [DATA_WD-1:0] a_pwdata,
  input  logic [PROT_WD-1:0] a_pprot,
  input  logic [STRB_WD-1:0] a_pstrb,
  output logic [DATA_WD-1:0] a_prdata,
  output logic               a_pready,
  output logic               a_apb_req,
  output logic               write,
  output logic [ADDR_WD-1:0] addr,
  output logic [DATA_WD-1:0] wdata,
  output logic [PROT_WD-1:0] prot,
  output logic [STRB_WD-1:0] strb,
  input  logic               b_ready_req,
  input  logic [DATA_WD-1:0] rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic               write_q, write_d;
  logic [ADDR_WD-1:0] addr_q, addr_d;
  logic [DATA_WD-1:0] wdata_q, wdata_d;
  logic [PROT_WD-1:0] prot_q, prot_d;
  logic [STRB_WD-1:0] strb_q, strb_d;
  logic [DATA_WD-1:0] prdata_q, prdata_d;
  logic [2:0]         sync_q, sync_d;
  logic               ack_edge;

  // sync_q[0] is the metastability catcher; the edge is taken between the two later stages.
  assign sync_d   = {sync_q[1:0], b_ready_req};
  assign ack_edge = sync_q[1] ^ sync_q[2];

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    prot_d   = prot_q;
    strb_d   = strb_q;
    prdata_d = prdata_q;
    case (state_q)
      IDLE: begin
        if (a_psel && !a_penable) begin
          write_d = a_pwrite;
          addr_d  = a_paddr;
          wdata_d = a_pwdata;
          prot_d  = a_pprot;
          strb_d  = a_pstrb;
          req_d   = ~req_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ack_edge) begin
          if (!write_q) prdata_d = rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge a_pclk) begin
    if (a_prst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      prot_q   <= '0;
      strb_q   <= '0;
      prdata_q <= '0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      prot_q   <= prot_d;
      strb_q   <= strb_d;
      prdata_q <= prdata_d;
      sync_q   <= sync_d;
    end
  end

  // Ready comes from state alone; reset masks a RESP cycle that is being cancelled.
  assign a_pready  = (state_q == RESP) && !a_prst;
  assign a_prdata  = prdata_q;
  assign a_apb_req = req_q;
  assign write     = write_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign prot      = prot_q;
  assign strb      = strb_q;

endmodule

// File: tb/tb_high_frequency_apb.sv
// Bench for high_frequency_apb: directed APB transfers with a decoupled response monitor.
module tb_high_frequency_apb;

  logic        clk;
  logic        a_prst;
  logic        a_psel;
  logic        a_penable;
  logic        a_pwrite;
  logic [31:0] a_paddr;
  logic [31:0] a_pwdata;
  logic [2:0]  a_pprot;
  logic [3:0]  a_pstrb;
  logic [31:0] a_prdata;
  logic        a_pready;
  logic        a_apb_req;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  prot;
  logic [3:0]  strb;
  logic        b_ready_req;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic        exp_req = 1'b0;
  logic [31:0] last_rd = 32'h0;
  // each entry: {expected a_pready cycle, expected a_prdata}
  logic [63:0] exp_q[$];

  high_frequency_apb dut (
    .a_pclk(clk), .a_prst(a_prst), .a_psel(a_psel), .a_penable(a_penable),
    .a_pwrite(a_pwrite), .a_paddr(a_paddr), .a_pwdata(a_pwdata), .a_pprot(a_pprot),
    .a_pstrb(a_pstrb), .a_prdata(a_prdata), .a_pready(a_pready), .a_apb_req(a_apb_req),
    .write(write), .addr(addr), .wdata(wdata), .prot(prot), .strb(strb),
    .b_ready_req(b_ready_req), .rdata(rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops one expected response per a_pready cycle
  initial begin
    logic [63:0] e;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (a_pready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pready", 64'(a_pready), 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("pready_cycle", 64'(cyc), {32'h0, e[63:32]});
          check("prdata", {32'h0, a_prdata}, {32'h0, e[31:0]});
        end
      end
    end
  end

  // driver tasks: all inputs change on the falling edge
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_psel = 1'b0;
      a_penable = 1'b0;
    end
  endtask

  task automatic setup(input logic w, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr);
    @(negedge clk);
    a_psel = 1'b1; a_penable = 1'b0; a_pwrite = w;
    a_paddr = ad; a_pwdata = wd; a_pstrb = st; a_pprot = pr;
    @(negedge clk);
    a_penable = 1'b1;
    exp_req = ~exp_req;
    check("req_toggle", 64'(a_apb_req), 64'(exp_req));
    check("write", 64'(write), 64'(w));
    check("addr", {32'h0, addr}, {32'h0, ad});
    check("wdata", {32'h0, wdata}, {32'h0, wd});
    check("strb_prot", {57'h0, strb, prot}, {57'h0, st, pr});
  endtask

  // toggle the B-side acknowledge; a real completion expects a_pready three edges later
  task automatic ack(input logic [31:0] rd, input logic expect_resp, input logic is_read);
    @(negedge clk);
    rdata = rd;
    b_ready_req = ~b_ready_req;
    if (expect_resp) begin
      if (is_read) last_rd = rd;
      exp_q.push_back({32'(cyc + 3), last_rd});
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    a_prst = 1'b1; a_psel = 1'b0; a_penable = 1'b0; a_pwrite = 1'b0;
    a_paddr = '0; a_pwdata = '0; a_pprot = '0; a_pstrb = '0;
    b_ready_req = 1'b0; rdata = '0;
    repeat (3) @(negedge clk);
    check("pready_in_reset", 64'(a_pready), 64'h0);
    a_prst = 1'b0;
    @(negedge clk);
    check("reset_req", 64'(a_apb_req), 64'h0);
    check("reset_payload", {write, addr, wdata[30:0]}, 64'h0);
    check("reset_prdata", {32'h0, a_prdata}, 64'h0);

    // write, acknowledged 5 cycles later; a_prdata must not change
    setup(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0);
    repeat (4) begin
      @(negedge clk);
      check("wait_no_pready", 64'(a_pready), 64'h0);
    end
    ack(32'hAAAA5555, 1'b1, 1'b0);

    // read, then a back-to-back write in the cycle after RESP
    idle(2);
    setup(1'b0, 32'h20, 32'h0, 4'h0, 3'd1);
    ack(32'h12345678, 1'b1, 1'b1);
    setup(1'b1, 32'h24, 32'h0BADF00D, 4'h3, 3'd5);
    ack(32'h00000055, 1'b1, 1'b0);

    // spurious acknowledge in IDLE
    idle(2);
    ack(32'hFFFFFFFF, 1'b0, 1'b0);
    idle(6);
    check("spur_addr", {32'h0, addr}, 64'h24);
    check("spur_req", 64'(a_apb_req), 64'(exp_req));
    check("spur_prdata", {32'h0, a_prdata}, 64'h12345678);

    // hold: bus activity during WAIT, including a new setup phase and dropped psel
    setup(1'b0, 32'h30, 32'h11111111, 4'h1, 3'd2);
    @(negedge clk);
    a_psel = 1'b1; a_penable = 1'b0; a_pwrite = 1'b1;
    a_paddr = 32'hFFFF0000; a_pwdata = 32'h99999999; a_pstrb = 4'hE; a_pprot = 3'd7;
    @(negedge clk);
    check("hold_addr", {32'h0, addr}, 64'h30);
    check("hold_wdata", {32'h0, wdata}, 64'h11111111);
    check("hold_ctl", {56'h0, write, strb, prot}, {56'h0, 1'b0, 4'h1, 3'd2});
    check("hold_req", 64'(a_apb_req), 64'(exp_req));
    check("hold_pready", 64'(a_pready), 64'h0);
    a_psel = 1'b0; a_penable = 1'b0;
    @(negedge clk);
    ack(32'hCAFEF00D, 1'b1, 1'b1);

    // reset while waiting, then a late acknowledge that must be ignored
    idle(2);
    setup(1'b1, 32'h40, 32'h44444444, 4'hF, 3'd3);
    @(negedge clk);
    a_prst = 1'b1;
    @(negedge clk);
    a_prst = 1'b0; a_psel = 1'b0; a_penable = 1'b0;
    exp_req = 1'b0;
    last_rd = 32'h0;
    check("rst_req", 64'(a_apb_req), 64'h0);
    check("rst_payload", {write, addr, wdata[30:0]}, 64'h0);
    check("rst_prdata", {32'h0, a_prdata}, 64'h0);
    ack(32'h77777777, 1'b0, 1'b0);
    idle(6);
    check("late_ack_req", 64'(a_apb_req), 64'h0);
    setup(1'b0, 32'h44, 32'h0, 4'h0, 3'd0);
    ack(32'h87654321, 1'b1, 1'b1);
    idle(2);

    // drain, bounded
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("responses_pending", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
